data_memory_line: RTL
=====================

Name: data_memory_line

Overview:
- Parametrised, multi-cycle, line-granular successor to the single-word data memory.
- Serves the cache controller in MULTI_CYCLE_CACHE: whole-line refills (read) and write-backs (write).
- Fixed programmable access latency models slow main memory.
- Single outstanding request; valid/ready on request side, one-cycle response pulse.

Parameters:
- DATA_WIDTH, 32, bits per word.
- DEPTH_WORDS, 4096, total words of storage (power of two).
- LINE_WORDS, 4, words per line (power of two, 1..16).
- LATENCY, 4, cycles spent in BUSY per access (>=1).
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = line write-back, 0 = line read.
- req_addr  in  ADDR_WIDTH  byte address; offset bits below line size ignored.
- req_wdata  in  LINE_WORDS*DATA_WIDTH  write line; word 0 in bits [DATA_WIDTH-1:0].
- resp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- resp_rdata  out  LINE_WORDS*DATA_WIDTH  read line; valid only while resp_valid=1 for a read.
- busy  out  1  high in BUSY or RESP.

Behaviour:
- Derived constants:
  - WORD_OFF = log2(DATA_WIDTH/8).
  - LINE_OFF = WORD_OFF + log2(LINE_WORDS).
  - NUM_LINES = DEPTH_WORDS/LINE_WORDS.
  - line index = req_addr[LINE_OFF+log2(NUM_LINES)-1 : LINE_OFF].
  - Upper address bits are ignored, so addresses wrap modulo memory size.
- Storage is an array of NUM_LINES lines. It is not cleared by reset; contents are X until written or preloaded by the bench.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture req_write, line index and req_wdata into holding registers.
  - Load counter with LATENCY-1, go to BUSY.
  - Request inputs are don't-care after the handshake.
- BUSY:
  - req_ready=0; counter decrements each cycle.
  - When counter==0:
    - write: commit the held line to storage on this edge.
    - read: register the line into resp_rdata on this edge.
    - go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then go to IDLE.
  - No response backpressure: the consumer must sample in that cycle.
- Timing: handshake at edge N gives resp_valid high during cycle N+LATENCY+1. req_ready is high again in cycle N+LATENCY+2. Back-to-back throughput is one request per LATENCY+2 cycles.
- Read-after-write to the same line returns the new data, because the write commits before RESP.
- req_valid while not ready is ignored. The requester must hold its request until it sees ready; nothing is queued.
- resp_rdata holds its last read value until the next read completes. Writes do not change it.
- Reset values (asserted low, asynchronous): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, busy=0, holding registers=0, req_ready=1 once reset deasserts.
- Reset mid-operation:
  - Abort the access, return to IDLE, emit no resp_valid.
  - A write not yet committed (counter!=0) is dropped; storage is unchanged.
- Elaboration: LATENCY<1 or a non-power-of-two DEPTH_WORDS/LINE_WORDS is an elaboration error ($error in an initial check).

Decomposition:
- Shared package mem_pkg holds:
  - FSM state enum (IDLE/BUSY/RESP).
  - default DATA_WIDTH/LINE_WORDS/DEPTH_WORDS constants, shared with the cache controller.
  - a clog2-based helper for offset widths.
- One natural sub-module: mem_line_array. It is a synchronous line-wide storage array with a single write port (we, idx, wline) and a registered read port (re, idx, rline). The FSM and counter stay in the top.

Test Plan:
- Defaults (LATENCY=4, LINE_WORDS=4): reset low 3 cycles, release -> req_ready=1, resp_valid=0, busy=0.
- Write 0x100 = {0x11111111, 0x22222222, 0x33333333, 0x44444444}, handshake at edge N -> resp_valid exactly in cycle N+5, req_ready low cycles N+1..N+5. Then read 0x10C -> same line returned (offset ignored), word0=0x11111111.
- Read address 0x4100 (wraps to 0x100 with 16KB) -> returns the line at 0x100.
- req_valid held high during BUSY with a different address -> ignored. Response matches the first request; the second is accepted when ready rises.
- Write to 0x200 with reset pulsed low at the 2nd BUSY cycle -> no resp_valid. Subsequent read of 0x200 returns its prior contents (preloaded 0xCAFEBABE in word0).
- LATENCY=1, LINE_WORDS=1 instance: read 0x0 preloaded 0xDEADBEEF -> resp_valid at N+2, resp_rdata=0xDEADBEEF. Back-to-back requests are accepted every 3 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions: access FSM states, default geometry
// and offset-width helpers used by the line memory and the cache controller.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam int MEM_DATA_WIDTH  = 32;
    localparam int MEM_LINE_WORDS  = 4;
    localparam int MEM_DEPTH_WORDS = 4096;

    // Number of address bits consumed by n items; a single item needs none.
    function automatic int offset_bits(input int n);
        return (n <= 1) ? 0 : $clog2(n);
    endfunction

    // Width of a field able to index n items, never narrower than one bit.
    function automatic int field_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// Line-wide storage: one synchronous write port and a registered read port
// that holds its last value until the next read.
module mem_line_array #(
    parameter int LINE_BITS = 128,
    parameter int NUM_LINES = 1024,
    parameter int IDX_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic                 re,
    input  logic [IDX_W-1:0]     idx,
    input  logic [LINE_BITS-1:0] wline,
    output logic [LINE_BITS-1:0] rline
);

    logic [LINE_BITS-1:0] mem_r [NUM_LINES];
    logic [LINE_BITS-1:0] rline_r;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wline;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rline_r <= '0;
        end else if (re) begin
            rline_r <= mem_r[idx];
        end
    end

    assign rline = rline_r;

endmodule

// File: rtl/data_memory_line.sv
// Multi-cycle line-granular main memory model: single outstanding request,
// fixed access latency, one-cycle completion pulse for reads and writes.
module data_memory_line
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int DEPTH_WORDS = MEM_DEPTH_WORDS,
    parameter int LINE_WORDS  = MEM_LINE_WORDS,
    parameter int LATENCY     = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
    output logic                             resp_valid,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata,
    output logic                             busy
);

    localparam int WORD_OFF  = offset_bits(DATA_WIDTH / 8);
    localparam int LINE_OFF  = WORD_OFF + offset_bits(LINE_WORDS);
    localparam int NUM_LINES = DEPTH_WORDS / LINE_WORDS;
    localparam int IDX_W     = field_width(NUM_LINES);
    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
    localparam int CNT_W     = field_width(LATENCY);

    if (LATENCY < 1) begin : g_bad_latency
        $error("data_memory_line: LATENCY must be at least 1");
    end
    if (!is_pow2(DEPTH_WORDS) || !is_pow2(LINE_WORDS)) begin : g_bad_geometry
        $error("data_memory_line: DEPTH_WORDS and LINE_WORDS must be powers of two");
    end

    mem_state_e           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 hold_write_r;
    logic [IDX_W-1:0]     hold_idx_r;
    logic [LINE_BITS-1:0] hold_wdata_r;
    logic                 req_ready_r;
    logic                 resp_valid_r;
    logic                 busy_r;
    logic                 commit_s;
    logic                 we_s;
    logic                 re_s;
    logic                 unused_addr_s;

    // The access completes on the last BUSY edge; writes land before RESP so
    // a following read of the same line sees the new data.
    assign commit_s = (state_r == ST_BUSY) && (cnt_r == {CNT_W{1'b0}});
    assign we_s     = commit_s && hold_write_r;
    assign re_s     = commit_s && !hold_write_r;

    // Offset and upper address bits are intentionally ignored (wrap-around).
    assign unused_addr_s = ^req_addr;

    // Access sequencer: request capture, latency count and response pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            hold_write_r <= 1'b0;
            hold_idx_r   <= '0;
            hold_wdata_r <= '0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    resp_valid_r <= 1'b0;
                    if (req_valid) begin
                        hold_write_r <= req_write;
                        hold_idx_r   <= req_addr[LINE_OFF +: IDX_W];
                        hold_wdata_r <= req_wdata;
                        cnt_r        <= CNT_W'(LATENCY - 1);
                        state_r      <= ST_BUSY;
                        req_ready_r  <= 1'b0;
                        busy_r       <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r      <= ST_RESP;
                        resp_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_r      <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    cnt_r        <= '0;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    mem_line_array #(
        .LINE_BITS (LINE_BITS),
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (reset),
        .we    (we_s),
        .re    (re_s),
        .idx   (hold_idx_r),
        .wline (hold_wdata_r),
        .rline (resp_rdata)
    );

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign busy       = busy_r;

endmodule
